// File: rtl/dram_word_adapter.sv
// dram_word_adapter
//   Turns 32-bit CPU load/store requests into single-beat 128-bit line commands
//   on the DRAM controller user port. A one-line read buffer serves repeated
//   loads to the same 16-byte line without a DRAM access. Stores are
//   write-through with byte masks. One request is outstanding at a time.
//
// Ports
//   ui_clk, ui_rst            clock, synchronous active-high reset
//   i_req_valid/we/addr/wdata/be, o_req_ready   CPU request channel
//   o_resp_valid, o_resp_rdata                  CPU response (1-cycle pulse)
//   i_dram_calib, i_dram_ready                  controller status
//   o_dram_rd_en, o_dram_wr_en                  1-cycle command pulses
//   o_dram_addr/data/mask                       command payload, held ISSUE..RESP
//   i_dram_data, i_dram_data_valid              read line return
module dram_word_adapter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int USE_LINE_BUF   = 1
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    input  logic                      i_req_valid,
    input  logic                      i_req_we,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    input  logic [31:0]               i_req_wdata,
    input  logic [3:0]                i_req_be,
    output logic                      o_req_ready,
    output logic                      o_resp_valid,
    output logic [31:0]               o_resp_rdata,
    input  logic                      i_dram_calib,
    input  logic                      i_dram_ready,
    output logic                      o_dram_rd_en,
    output logic                      o_dram_wr_en,
    output logic [APP_ADDR_WIDTH-1:0] o_dram_addr,
    output logic [APP_DATA_WIDTH-1:0] o_dram_data,
    output logic [APP_MASK_WIDTH-1:0] o_dram_mask,
    input  logic [APP_DATA_WIDTH-1:0] i_dram_data,
    input  logic                      i_dram_data_valid
);

    localparam int TAG_W = ADDR_WIDTH - 4;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_WR_HOLD, S_WR_WAIT, S_RESP
    } state_t;

    state_t state;

    logic [TAG_W-1:0]          req_tag;
    logic [1:0]                req_lane;
    logic [31:0]               req_wdata;
    logic [3:0]                req_be;

    logic                      buf_valid;
    logic [TAG_W-1:0]          buf_tag;
    logic [APP_DATA_WIDTH-1:0] buf_data;

    logic [TAG_W-1:0]          in_tag;
    logic [1:0]                in_lane;
    logic                      in_hit;
    logic [ADDR_WIDTH-2:0]     full_addr;
    logic [APP_MASK_WIDTH-1:0] wmask;
    logic [APP_DATA_WIDTH-1:0] merged;
    logic                      store_hit;
    logic                      unused_bits;

    assign in_tag    = i_req_addr[ADDR_WIDTH-1:4];
    assign in_lane   = i_req_addr[3:2];
    assign in_hit    = (USE_LINE_BUF != 0) && buf_valid && (buf_tag == in_tag);
    // Controller addresses 16-bit units and appends its own LSB, so a 16-byte
    // line index is shifted up by 3.
    assign full_addr = {in_tag, 3'b000};
    assign store_hit = buf_valid && (buf_tag == req_tag);
    assign unused_bits = ^{i_req_addr[1:0], full_addr};

    assign o_req_ready = (state == S_IDLE) && i_dram_calib && !ui_rst;

    // Mask bit = 1 means the byte is NOT written; only the addressed lane opens.
    always_comb begin
        wmask = '1;
        wmask[4*in_lane +: 4] = ~i_req_be;
    end

    // Buffer line with the store bytes folded in, for write-through on a hit.
    always_comb begin
        merged = buf_data;
        for (int b = 0; b < 4; b++) begin
            if (req_be[b])
                merged[32*req_lane + 8*b +: 8] = req_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            state        <= S_IDLE;
            req_tag      <= '0;
            req_lane     <= '0;
            req_wdata    <= '0;
            req_be       <= '0;
            buf_valid    <= 1'b0;
            buf_tag      <= '0;
            buf_data     <= '0;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= '0;
            o_dram_rd_en <= 1'b0;
            o_dram_wr_en <= 1'b0;
            o_dram_addr  <= '0;
            o_dram_data  <= '0;
            o_dram_mask  <= '0;
        end else begin
            o_dram_rd_en <= 1'b0;
            o_dram_wr_en <= 1'b0;
            o_resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        req_tag     <= in_tag;
                        req_lane    <= in_lane;
                        req_wdata   <= i_req_wdata;
                        req_be      <= i_req_be;
                        o_dram_addr <= full_addr[APP_ADDR_WIDTH-1:0];
                        if (i_req_we) begin
                            o_dram_data <= {4{i_req_wdata}};
                            o_dram_mask <= wmask;
                            state       <= S_WR_ISSUE;
                        end else if (in_hit) begin
                            o_resp_valid <= 1'b1;
                            o_resp_rdata <= buf_data[32*in_lane +: 32];
                            state        <= S_RESP;
                        end else begin
                            state <= S_RD_ISSUE;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (i_dram_ready) begin
                        o_dram_rd_en <= 1'b1;
                        state        <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (i_dram_data_valid) begin
                        buf_valid    <= (USE_LINE_BUF != 0);
                        buf_tag      <= req_tag;
                        buf_data     <= i_dram_data;
                        o_resp_valid <= 1'b1;
                        o_resp_rdata <= i_dram_data[32*req_lane +: 32];
                        state        <= S_RESP;
                    end
                end
                S_WR_ISSUE: begin
                    if (i_dram_ready) begin
                        o_dram_wr_en <= 1'b1;
                        if (store_hit)
                            buf_data <= merged;
                        state <= S_WR_HOLD;
                    end
                end
                // Controller's ready lags the write command by a cycle; skip it.
                S_WR_HOLD: state <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (i_dram_ready) begin
                        o_resp_valid <= 1'b1;
                        o_resp_rdata <= '0;
                        state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    o_resp_rdata <= '0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_word_adapter.sv
module tb_dram_word_adapter;

    logic         ui_clk, ui_rst;
    logic         i_req_valid, i_req_we;
    logic [31:0]  i_req_addr, i_req_wdata;
    logic [3:0]   i_req_be;
    logic         o_req_ready, o_resp_valid;
    logic [31:0]  o_resp_rdata;
    logic         i_dram_calib, i_dram_ready;
    logic         o_dram_rd_en, o_dram_wr_en;
    logic [27:0]  o_dram_addr;
    logic [127:0] o_dram_data;
    logic [15:0]  o_dram_mask;
    logic [127:0] i_dram_data;
    logic         i_dram_data_valid;

    dram_word_adapter dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst),
        .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .i_req_be(i_req_be), .o_req_ready(o_req_ready),
        .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
        .i_dram_calib(i_dram_calib), .i_dram_ready(i_dram_ready),
        .o_dram_rd_en(o_dram_rd_en), .o_dram_wr_en(o_dram_wr_en),
        .o_dram_addr(o_dram_addr), .o_dram_data(o_dram_data), .o_dram_mask(o_dram_mask),
        .i_dram_data(i_dram_data), .i_dram_data_valid(i_dram_data_valid)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    int tests = 0, fails = 0;

    // Reference state: DRAM contents as a sparse line store, plus the tag of
    // the line the adapter should currently be buffering. Write-through keeps
    // the buffered copy equal to memory, so load data always comes from mem.
    logic [127:0] mem [int unsigned];
    bit           mb_v;
    int unsigned  mb_tag;

    bit           busy, auto_rsp, rdy_rand;
    logic [27:0]  exp_addr;
    logic [127:0] exp_wdata;
    logic [15:0]  exp_wmask;
    logic [31:0]  exp_rdata;
    int           rd_cnt, wr_cnt, resp_cnt;
    logic [31:0]  last_rdata;
    logic [127:0] last_wdata;
    logic [15:0]  last_wmask;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mem_get(input int unsigned k);
        if (mem.exists(k)) return mem[k];
        return {k ^ 32'h0A0B_0C0D, k * 3, ~k, k + 32'h1234};
    endfunction

    // Compare process: every cycle, sampled on the falling edge.
    always @(negedge ui_clk) begin
        chk("req_ready", o_req_ready, i_dram_calib && !busy && !ui_rst);
        if (o_dram_rd_en) begin
            rd_cnt++;
            chk("rd_addr", o_dram_addr, exp_addr);
        end
        if (o_dram_wr_en) begin
            wr_cnt++;
            last_wdata = o_dram_data;
            last_wmask = o_dram_mask;
            chk("wr_addr", o_dram_addr, exp_addr);
            chk("wr_data", o_dram_data, exp_wdata);
            chk("wr_mask", o_dram_mask, exp_wmask);
        end
        if (o_resp_valid) begin
            resp_cnt++;
            last_rdata = o_resp_rdata;
            chk("resp_rdata", o_resp_rdata, exp_rdata);
        end
    end

    // Controller ready: random back-pressure.
    always begin
        @(posedge ui_clk); #1;
        i_dram_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // DRAM read responder: returns the addressed line 1..3 cycles after rd_en.
    always begin
        @(negedge ui_clk);
        if (o_dram_rd_en && auto_rsp) begin
            logic [127:0] ln;
            ln = mem_get(32'(o_dram_addr[27:3]));
            repeat ($urandom_range(1, 3)) @(posedge ui_clk);
            #1;
            i_dram_data = ln;
            i_dram_data_valid = 1'b1;
            @(posedge ui_clk); #1;
            i_dram_data_valid = 1'b0;
            i_dram_data = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // One request start-to-finish; caller is at posedge+1.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rdata,
                          output int nrd, output int lat);
        logic [27:0]  k;
        logic [1:0]   l;
        logic [127:0] line;
        bit           hit;
        int           rd0, wr0, n;
        k    = addr[31:4];
        l    = addr[3:2];
        line = mem_get(32'(k));
        hit  = !we && mb_v && (mb_tag == 32'(k));
        exp_addr = {k[24:0], 3'b000};
        if (we) begin
            exp_rdata = '0;
            exp_wdata = {4{wd}};
            exp_wmask = '1;
            exp_wmask[4*l +: 4] = ~be;
            for (int b = 0; b < 4; b++)
                if (be[b]) line[32*l + 8*b +: 8] = wd[8*b +: 8];
            mem[32'(k)] = line;
        end else begin
            exp_rdata = line[32*l +: 32];
            if (!hit) begin
                mb_v = 1'b1;
                mb_tag = 32'(k);
            end
        end
        rd0 = rd_cnt; wr0 = wr_cnt;
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr;
        i_req_wdata = wd; i_req_be = be;
        n = 0;
        forever begin
            @(negedge ui_clk);
            if (o_req_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) chk("accept_timeout", 1, 0);
        @(posedge ui_clk); #1;
        i_req_valid = 1'b0;
        busy = 1'b1;
        lat = 0;
        forever begin
            @(negedge ui_clk);
            lat++;
            if (o_resp_valid || lat > 500) break;
        end
        if (lat > 500) chk("resp_timeout", 1, 0);
        @(posedge ui_clk); #1;
        busy = 1'b0;
        nrd = rd_cnt - rd0;
        rdata = last_rdata;
        chk("n_rd", nrd, (!we && !hit) ? 1 : 0);
        chk("n_wr", wr_cnt - wr0, we ? 1 : 0);
        if (hit) chk("hit_latency", lat, 1);
    endtask

    initial begin
        logic [31:0] rd;
        int          nrd, lat, n, r0;
        ui_rst = 1'b1; i_dram_calib = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0;
        i_req_addr = '0; i_req_wdata = '0; i_req_be = '0;
        i_dram_data = '0; i_dram_data_valid = 1'b0;
        busy = 0; auto_rsp = 1; rdy_rand = 1; mb_v = 0; mb_tag = 0;
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
        mem[32'h10] = 128'h44444444_33333333_22222222_11111111;

        // Reset: outputs cleared, no ready until calibration completes.
        repeat (3) @(posedge ui_clk);
        @(negedge ui_clk);
        chk("rst_outputs", {o_resp_valid, o_resp_rdata, o_dram_rd_en, o_dram_wr_en,
                            o_dram_addr, o_dram_mask}, '0);
        chk("rst_wdata", o_dram_data, '0);
        @(posedge ui_clk); #1;
        ui_rst = 1'b0;
        repeat (3) @(posedge ui_clk);
        @(negedge ui_clk);
        chk("ready_nocalib", o_req_ready, 0);
        @(posedge ui_clk); #1;
        i_dram_calib = 1'b1;
        @(negedge ui_clk);
        chk("ready_calib", o_req_ready, 1);
        @(posedge ui_clk); #1;

        // Cold load of 0x104: miss, line index 0x10 -> controller addr 0x80.
        do_req(0, 32'h0000_0104, 0, 0, rd, nrd, lat);
        chk("t2_rdata", rd, 32'h22222222);
        chk("t2_nrd", nrd, 1);
        // Same line again: served from the buffer.
        do_req(0, 32'h0000_0108, 0, 0, rd, nrd, lat);
        chk("t3_rdata", rd, 32'h33333333);
        chk("t3_lat", lat, 1);
        // Partial store into lane 3: bytes 12,13 written, so only mask bits
        // 12 and 13 are cleared.
        do_req(1, 32'h0000_010C, 32'hAABBCCDD, 4'b0011, rd, nrd, lat);
        chk("t4_mask", last_wmask, 16'hCFFF);
        chk("t4_data", last_wdata, {4{32'hAABBCCDD}});
        chk("t4_rsp_rdata", rd, 0);
        do_req(0, 32'h0000_010C, 0, 0, rd, nrd, lat);
        chk("t4_reload", rd, 32'h4444CCDD);
        chk("t4_reload_nrd", nrd, 0);
        // Store elsewhere leaves the buffered line alone.
        do_req(1, 32'h0000_0200, 32'h12345678, 4'b1111, rd, nrd, lat);
        do_req(0, 32'h0000_0104, 0, 0, rd, nrd, lat);
        chk("t5_rdata", rd, 32'h22222222);
        chk("t5_nrd", nrd, 0);

        // Reset during RD_WAIT, then a stale line return.
        auto_rsp = 0;
        exp_addr = 28'h180;
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h0000_0304;
        n = 0;
        forever begin
            @(negedge ui_clk);
            if (o_req_ready || n > 100) break;
            n++;
        end
        @(posedge ui_clk); #1;
        i_req_valid = 1'b0; busy = 1'b1;
        r0 = rd_cnt; n = 0;
        while (rd_cnt == r0 && n < 100) begin
            @(negedge ui_clk);
            n++;
        end
        chk("t6_rd_seen", rd_cnt - r0, 1);
        @(posedge ui_clk); #1;
        ui_rst = 1'b1; busy = 1'b0; mb_v = 0;
        repeat (2) @(posedge ui_clk);
        #1;
        ui_rst = 1'b0;
        i_dram_data = mem_get(32'h30);
        i_dram_data_valid = 1'b1;
        @(posedge ui_clk); #1;
        i_dram_data_valid = 1'b0;
        r0 = resp_cnt;
        repeat (5) @(posedge ui_clk);
        #1;
        chk("t6_stale_ignored", resp_cnt - r0, 0);
        auto_rsp = 1;
        do_req(0, 32'h0000_0104, 0, 0, rd, nrd, lat);
        chk("t6_nrd", nrd, 1);
        chk("t6_rdata", rd, 32'h22222222);

        // Random traffic over a few lines so hits, misses and store hits mix.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 15) == 0) begin
                i_dram_calib = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge ui_clk);
                #1;
                i_dram_calib = 1'b1;
            end
            a = {16'h0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 2)), 8'($urandom)};
            if ($urandom_range(0, 2) == 0)
                do_req(1, a, $urandom, 4'($urandom), rd, nrd, lat);
            else
                do_req(0, a, 0, 0, rd, nrd, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
